// File: rtl/reg_writeback_stage_pkg.sv
// Shared types for the writeback stage: source select, load type and FSM state.
package reg_writeback_stage_pkg;

  typedef enum logic [1:0] {
    SelAlu  = 2'b00,
    SelMem  = 2'b01,
    SelImm  = 2'b10,
    SelLink = 2'b11
  } wb_select_t;

  // Code 3'b111 is left unassigned and is treated as LW by the formatter.
  typedef enum logic [2:0] {
    LdLw  = 3'b000,
    LdLb  = 3'b001,
    LdLbu = 3'b010,
    LdLh  = 3'b011,
    LdLhu = 3'b100,
    LdLwl = 3'b101,
    LdLwr = 3'b110
  } load_type_t;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitMem = 1'b1
  } wb_state_t;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/reg_writeback_stage_load_formatter.sv
// Combinational load aligner: little-endian byte/halfword extraction and LWL/LWR merge.
module reg_writeback_stage_load_formatter
  import reg_writeback_stage_pkg::*;
(
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_rt_old,
  output logic [31:0] o_fmt_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  always_comb begin
    w_byte = i_mem_word[7:0];
    w_lwl  = i_mem_word;
    w_lwr  = i_mem_word;
    unique case (i_byte_off)
      2'd0: begin
        w_byte = i_mem_word[7:0];
        w_lwl  = {i_mem_word[7:0], i_rt_old[23:0]};
        w_lwr  = i_mem_word;
      end
      2'd1: begin
        w_byte = i_mem_word[15:8];
        w_lwl  = {i_mem_word[15:0], i_rt_old[15:0]};
        w_lwr  = {i_rt_old[31:24], i_mem_word[31:8]};
      end
      2'd2: begin
        w_byte = i_mem_word[23:16];
        w_lwl  = {i_mem_word[23:0], i_rt_old[7:0]};
        w_lwr  = {i_rt_old[31:16], i_mem_word[31:16]};
      end
      2'd3: begin
        w_byte = i_mem_word[31:24];
        w_lwl  = i_mem_word;
        w_lwr  = {i_rt_old[31:8], i_mem_word[31:24]};
      end
      default: begin
        w_byte = i_mem_word[7:0];
        w_lwl  = i_mem_word;
        w_lwr  = i_mem_word;
      end
    endcase
  end

  // Halfword lane is picked by byte_off[1] alone; byte_off[0] is don't-care.
  assign w_half = i_byte_off[1] ? i_mem_word[31:16] : i_mem_word[15:0];

  always_comb begin
    o_fmt_word = i_mem_word;
    case (i_load_type)
      LdLb:    o_fmt_word = sext8(w_byte);
      LdLbu:   o_fmt_word = {24'd0, w_byte};
      LdLh:    o_fmt_word = sext16(w_half);
      LdLhu:   o_fmt_word = {16'd0, w_half};
      LdLwl:   o_fmt_word = w_lwl;
      LdLwr:   o_fmt_word = w_lwr;
      default: o_fmt_word = i_mem_word;
    endcase
  end

endmodule

// File: rtl/reg_writeback_stage.sv
// Handshaked MIPS writeback stage with multi-cycle load wait and one-cycle register-file strobe.
// Sub-word load formatting is built only when WB_SUBWORD_EN is defined.
module reg_writeback_stage
  import reg_writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            select,
  input  logic [2:0]            load_type,
  input  logic [1:0]            byte_off,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [DATA_W-1:0]     aluout,
  input  logic [DATA_W-1:0]     signextend_data,
  input  logic [DATA_W-1:0]     link_pc,
  input  logic [DATA_W-1:0]     rt_old,
  input  logic [DATA_W-1:0]     mem_readdata,
  input  logic                  mem_readvalid,
  output logic                  reg_write_enable,
  output logic [REG_ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0]     reg_write_data
);

  wb_state_t             r_state;
  wb_state_t             w_state_next;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;

  logic                  w_accept;
  logic                  w_done;
  logic [DATA_W-1:0]     w_result;
  logic [REG_ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0]     w_mem_fmt;

  assign in_ready = (r_state == StIdle);
  assign w_accept = in_valid && in_ready;
  // Requests finishing in the acceptance cycle use live fields; waiting loads use latched ones.
  assign w_dest   = (r_state == StWaitMem) ? r_dest : dest;

`ifdef WB_SUBWORD_EN
  logic [2:0]        r_load_type;
  logic [1:0]        r_byte_off;
  logic [DATA_W-1:0] r_rt_old;
  logic [2:0]        w_fmt_load_type;
  logic [1:0]        w_fmt_byte_off;
  logic [DATA_W-1:0] w_fmt_rt_old;

  assign w_fmt_load_type = (r_state == StWaitMem) ? r_load_type : load_type;
  assign w_fmt_byte_off  = (r_state == StWaitMem) ? r_byte_off  : byte_off;
  assign w_fmt_rt_old    = (r_state == StWaitMem) ? r_rt_old    : rt_old;

  reg_writeback_stage_load_formatter u_load_formatter (
    .i_load_type (w_fmt_load_type),
    .i_byte_off  (w_fmt_byte_off),
    .i_mem_word  (mem_readdata),
    .i_rt_old    (w_fmt_rt_old),
    .o_fmt_word  (w_mem_fmt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_type <= '0;
      r_byte_off  <= '0;
      r_rt_old    <= '0;
    end else if (w_accept) begin
      r_load_type <= load_type;
      r_byte_off  <= byte_off;
      r_rt_old    <= rt_old;
    end
  end
`else
  logic w_unused_subword;
  assign w_unused_subword = ^{load_type, byte_off, rt_old};
  assign w_mem_fmt        = mem_readdata;
`endif

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_result     = aluout;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (select == SelMem) begin
            if (mem_readvalid) begin
              w_done   = 1'b1;
              w_result = w_mem_fmt;
            end else begin
              w_state_next = StWaitMem;
            end
          end else begin
            w_done = 1'b1;
            case (select)
              SelImm:  w_result = signextend_data;
              SelLink: w_result = link_pc;
              default: w_result = aluout;
            endcase
          end
        end
      end
      StWaitMem: begin
        if (mem_readvalid) begin
          w_done       = 1'b1;
          w_result     = w_mem_fmt;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_dest  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      // Register $zero is never written, but its data is still captured.
      r_we    <= w_done && (w_dest != '0);
      if (w_done) begin
        r_addr <= w_dest;
        r_data <= w_result;
      end
      if (w_accept) begin
        r_dest <= dest;
      end
    end
  end

  assign reg_write_enable = r_we;
  assign reg_write_addr   = r_addr;
  assign reg_write_data   = r_data;

endmodule

// File: tb/tb_reg_writeback_stage.sv
// Self-checking bench for reg_writeback_stage: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_reg_writeback_stage;

`ifdef WB_SUBWORD_EN
  localparam bit SubwordEn = 1'b1;
`else
  localparam bit SubwordEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  select;
  logic [2:0]  load_type;
  logic [1:0]  byte_off;
  logic [4:0]  dest;
  logic [31:0] aluout;
  logic [31:0] signextend_data;
  logic [31:0] link_pc;
  logic [31:0] rt_old;
  logic [31:0] mem_readdata;
  logic        mem_readvalid;
  logic        reg_write_enable;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  reg_writeback_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .select           (select),
    .load_type        (load_type),
    .byte_off         (byte_off),
    .dest             (dest),
    .aluout           (aluout),
    .signextend_data  (signextend_data),
    .link_pc          (link_pc),
    .rt_old           (rt_old),
    .mem_readdata     (mem_readdata),
    .mem_readvalid    (mem_readvalid),
    .reg_write_enable (reg_write_enable),
    .reg_write_addr   (reg_write_addr),
    .reg_write_data   (reg_write_data)
  );

  always #5 clk = ~clk;

  // Reference: little-endian lanes, sign/zero extension by arithmetic, merges by shift and mask.
  function automatic logic [31:0] model_load(input int lt, input int off,
                                             input logic [31:0] mem, input logic [31:0] rt);
    longint m;
    longint r;
    longint b;
    longint h;
    longint res;
    int     s;
    m = longint'(mem);
    r = longint'(rt);
    b = (m >> (8 * off)) & 64'hFF;
    h = (m >> (16 * (off / 2))) & 64'hFFFF;
    case (lt)
      1: res = (b >= 128) ? b - 256 : b;
      2: res = b;
      3: res = (h >= 32768) ? h - 65536 : h;
      4: res = h;
      5: begin
        s   = 8 * (3 - off);
        res = (m << s) | (r & ((64'sd1 << s) - 1));
      end
      6: begin
        s   = 8 * off;
        res = (m >> s) | (r & ~(64'hFFFFFFFF >> s));
      end
      default: res = m;
    endcase
    return res[31:0];
  endfunction

  function automatic logic [31:0] model_result(input int sel, input int lt, input int off,
      input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] link,
      input logic [31:0] rt, input logic [31:0] mem);
    case (sel)
      0: return alu;
      1: return SubwordEn ? model_load(lt, off, mem, rt) : mem;
      2: return imm;
      default: return link;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid        = 1'b0;
    select          = 2'd0;
    load_type       = 3'd0;
    byte_off        = 2'd0;
    dest            = 5'd0;
    aluout          = 32'd0;
    signextend_data = 32'd0;
    link_pc         = 32'd0;
    rt_old          = 32'd0;
    mem_readdata    = 32'd0;
    mem_readvalid   = 1'b0;
  endtask

  // Randomizes every request field; in_valid is set by the caller.
  task automatic drive_junk(input logic valid);
    in_valid        = valid;
    select          = 2'($urandom);
    load_type       = 3'($urandom);
    byte_off        = 2'($urandom);
    dest            = 5'($urandom);
    aluout          = $urandom;
    signextend_data = $urandom;
    link_pc         = $urandom;
    rt_old          = $urandom;
    mem_readdata    = $urandom;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_we got=%0b want=0", reg_write_enable);
    end
    n_checks++;
    if (reg_write_addr !== 5'd0) begin
      n_fail++; $display("FAIL reset_addr got=%0d want=0", reg_write_addr);
    end
    n_checks++;
    if (reg_write_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_data got=%08h want=00000000", reg_write_data);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%0b want=1", in_ready);
    end
  endtask

  task automatic test_alu();
    set_idle();
    in_valid = 1'b1;
    select   = 2'd0;
    aluout   = 32'h1234_5678;
    dest     = 5'd5;
    tick();
    set_idle();
    n_checks++;
    if (reg_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL alu_we got=%0b want=1", reg_write_enable);
    end
    n_checks++;
    if (reg_write_addr !== 5'd5) begin
      n_fail++; $display("FAIL alu_addr got=%0d want=5", reg_write_addr);
    end
    n_checks++;
    if (reg_write_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alu_data got=%08h want=12345678", reg_write_data);
    end
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL alu_we_drop got=%0b want=0", reg_write_enable);
    end
  endtask

  int          lt_tab [12] = '{1, 2, 5, 6, 3, 4, 0, 7, 1, 5, 6, 4};
  int          off_tab[12] = '{3, 3, 1, 1, 2, 3, 2, 1, 0, 3, 0, 0};
  logic [31:0] mem_tab[12] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h1122_3344, 32'h1122_3344,
                               32'h80FF_7F01, 32'h80FF_7F01, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                               32'h80FF_7F01, 32'h1122_3344, 32'h1122_3344, 32'h80FF_7F01};

  // Loads answered in the acceptance cycle, issued back to back.
  task automatic test_load_formats();
    logic [31:0] exp;
    for (int i = 0; i < 12; i++) begin
      set_idle();
      in_valid      = 1'b1;
      select        = 2'd1;
      load_type     = 3'(lt_tab[i]);
      byte_off      = 2'(off_tab[i]);
      rt_old        = 32'hAABB_CCDD;
      mem_readdata  = mem_tab[i];
      mem_readvalid = 1'b1;
      dest          = 5'(i + 1);
      exp = model_result(1, lt_tab[i], off_tab[i], 32'd0, 32'd0, 32'd0, 32'hAABB_CCDD,
                         mem_tab[i]);
      tick();
      n_checks++;
      if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL load_strobe[%0d] got we=%0b addr=%0d want we=1 addr=%0d", i,
                 reg_write_enable, reg_write_addr, i + 1);
      end
      n_checks++;
      if (reg_write_data !== exp) begin
        n_fail++;
        $display("FAIL load_data[%0d] lt=%0d off=%0d got=%08h want=%08h", i, lt_tab[i],
                 off_tab[i], reg_write_data, exp);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL load_ready[%0d] got=%0b want=1", i, in_ready);
      end
    end
    set_idle();
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL load_we_drop got=%0b want=0", reg_write_enable);
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] exp;
    exp = model_result(1, 1, 3, 32'd0, 32'd0, 32'd0, 32'hAABB_CCDD, 32'h80FF_7F01);
    set_idle();
    in_valid  = 1'b1;
    select    = 2'd1;
    load_type = 3'd1;
    byte_off  = 2'd3;
    rt_old    = 32'hAABB_CCDD;
    dest      = 5'd7;
    tick();
    // Second request held during the wait, with fields that would corrupt an unlatched load.
    select       = 2'd0;
    aluout       = 32'hCAFE_F00D;
    dest         = 5'd9;
    load_type    = 3'd6;
    byte_off     = 2'd0;
    rt_old       = 32'h0;
    mem_readdata = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (in_ready !== 1'b0 || reg_write_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_stall[%0d] got ready=%0b we=%0b want ready=0 we=0", c, in_ready,
                 reg_write_enable);
      end
      if (c < 2) tick();
    end
    mem_readvalid = 1'b1;
    mem_readdata  = 32'h80FF_7F01;
    tick();
    mem_readvalid = 1'b0;
    n_checks++;
    if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'd7 || reg_write_data !== exp) begin
      n_fail++;
      $display("FAIL wait_result got we=%0b addr=%0d data=%08h want we=1 addr=7 data=%08h",
               reg_write_enable, reg_write_addr, reg_write_data, exp);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL wait_ready_back got=%0b want=1", in_ready);
    end
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'd9 ||
        reg_write_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL wait_second got we=%0b addr=%0d data=%08h want we=1 addr=9 data=cafef00d",
               reg_write_enable, reg_write_addr, reg_write_data);
    end
    set_idle();
    tick();
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL wait_we_drop got=%0b want=0", reg_write_enable);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    in_valid = 1'b1;
    select   = 2'd1;
    dest     = 5'd3;
    tick();
    set_idle();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_enter got=%0b want=0", in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (reg_write_enable !== 1'b0 || reg_write_data !== 32'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_async got we=%0b data=%08h ready=%0b want 0 00000000 1",
               reg_write_enable, reg_write_data, in_ready);
    end
    @(negedge clk);
    reset         = 1'b0;
    mem_readvalid = 1'b1;
    mem_readdata  = 32'h7777_1234;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (reg_write_enable !== 1'b0 || reg_write_addr !== 5'd0 || reg_write_data !== 32'd0 ||
          in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rstwait_late[%0d] got we=%0b addr=%0d data=%08h ready=%0b want 0 0 0 1",
                 c, reg_write_enable, reg_write_addr, reg_write_data, in_ready);
      end
    end
    set_idle();
  endtask

  task automatic test_link_dest0();
    set_idle();
    in_valid = 1'b1;
    select   = 2'd3;
    link_pc  = 32'h0040_0018;
    aluout   = 32'h1111_2222;
    dest     = 5'd0;
    tick();
    set_idle();
    n_checks++;
    if (reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL link0_we got=%0b want=0", reg_write_enable);
    end
    n_checks++;
    if (reg_write_data !== 32'h0040_0018 || reg_write_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL link0_data got addr=%0d data=%08h want addr=0 data=00400018",
               reg_write_addr, reg_write_data);
    end
    tick();
  endtask

  task automatic test_random();
    int          sel;
    int          lt;
    int          off;
    int          lat;
    int          gap;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] lnk;
    logic [31:0] rt;
    logic [31:0] mem;
    logic [31:0] exp;
    for (int n = 0; n < 300; n++) begin
      gap = int'($urandom_range(0, 3)) - 1;
      for (int g = 0; g < gap; g++) begin
        drive_junk(1'b0);
        mem_readvalid = 1'($urandom);
        tick();
        n_checks++;
        if (reg_write_enable !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_gap[%0d] got we=%0b ready=%0b want we=0 ready=1", n,
                   reg_write_enable, in_ready);
        end
      end
      sel = int'($urandom_range(0, 3));
      lt  = int'($urandom_range(0, 7));
      off = int'($urandom_range(0, 3));
      dst = 5'($urandom);
      alu = $urandom;
      imm = $urandom;
      lnk = $urandom;
      rt  = $urandom;
      mem = $urandom;
      lat = (sel == 1) ? int'($urandom_range(0, 3)) : 0;
      exp = model_result(sel, lt, off, alu, imm, lnk, rt, mem);
      in_valid        = 1'b1;
      select          = 2'(sel);
      load_type       = 3'(lt);
      byte_off        = 2'(off);
      dest            = dst;
      aluout          = alu;
      signextend_data = imm;
      link_pc         = lnk;
      rt_old          = rt;
      mem_readdata    = (lat == 0) ? mem : $urandom;
      mem_readvalid   = (sel == 1) ? (lat == 0) : 1'($urandom);
      tick();
      if (lat > 0) begin
        for (int w = 0; w < lat; w++) begin
          n_checks++;
          if (reg_write_enable !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_wait[%0d] got we=%0b ready=%0b want we=0 ready=0", n,
                     reg_write_enable, in_ready);
          end
          drive_junk(1'($urandom));
          mem_readvalid = (w == lat - 1);
          if (w == lat - 1) mem_readdata = mem;
          tick();
        end
      end
      n_checks++;
      if (reg_write_enable !== (dst != 5'd0) || reg_write_addr !== dst ||
          reg_write_data !== exp || in_ready !== 1'b1) begin
        n_fail++;
        $display({"FAIL rnd_result[%0d] sel=%0d lt=%0d off=%0d lat=%0d got we=%0b addr=%0d ",
                  "data=%08h ready=%0b want we=%0b addr=%0d data=%08h ready=1"},
                 n, sel, lt, off, lat, reg_write_enable, reg_write_addr, reg_write_data,
                 in_ready, dst != 5'd0, dst, exp);
      end
    end
    set_idle();
    tick();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_alu();
    test_load_formats();
    test_mem_wait();
    test_reset_mid_wait();
    test_link_dest0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback_stage.md
# reg_writeback_stage

Registered, handshaked writeback stage for the MIPS CPU. It selects the register-file write data from the ALU result, memory load data, sign-extended immediate or link PC, and aligns sub-word loads and LWL/LWR merges. It waits any number of cycles for load data to arrive, then presents a single-cycle write pulse to the register file. It sits between execute/memory and the register file, and adds a valid/ready handshake and multi-cycle memory latency to the writeback path.

## Interface

Parameters:
- DATA_W, 32, datapath width; must be 32 when `WB_SUBWORD_EN` is defined.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  writeback request present.
- in_ready  out  1  stage can accept a request this cycle.
- select  in  2  source: 00 ALU, 01 MEM, 10 IMM, 11 LINK.
- load_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR; ignored unless select=01.
- byte_off  in  2  effective address [1:0].
- dest  in  REG_ADDR_W  destination register.
- aluout, signextend_data, link_pc  in  DATA_W  source operands.
- rt_old  in  DATA_W  current rt value, used for the LWL/LWR merge.
- mem_readdata  in  DATA_W  load word from memory.
- mem_readvalid  in  1  mem_readdata valid this cycle.
- reg_write_enable  out  1  one-cycle write strobe.
- reg_write_addr  out  REG_ADDR_W  write index.
- reg_write_data  out  DATA_W  write value.

## Operation

- A request is accepted when in_valid and in_ready are both 1. On acceptance, select, load_type, byte_off, dest and rt_old are latched.
- FSM states: IDLE and WAIT_MEM.
- IDLE:
  - in_ready = 1.
  - For a non-MEM request, or a MEM request with mem_readvalid = 1 in the acceptance cycle, the result is registered and the FSM stays in IDLE.
  - For a MEM request with mem_readvalid = 0, the FSM goes to WAIT_MEM.
- WAIT_MEM:
  - in_ready = 0.
  - mem_readvalid is sampled each cycle. When it is 1, mem_readdata is formatted with the latched fields, the result is registered, and the FSM returns to IDLE.
- mem_readvalid is ignored in IDLE when no MEM request is being accepted.
- Load formatting uses little-endian lanes: byte k is bits [8k+7:8k], and a halfword uses lanes {2h+1, 2h} with h = byte_off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LWL: {mem[8k+7:0], rt_old[23-8k:0]}, where k = byte_off; k = 3 gives the whole memory word.
  - LWR: {rt_old[31:32-8k], mem[31:8k]}; k = 0 gives the whole memory word.
  - byte_off[0] is ignored for LH/LHU; byte_off is ignored for LW.
- When dest = 0, reg_write_enable is suppressed and the data is still registered.
- Unused load_type code 111 behaves as LW.

## Timing

- Reset values: state IDLE, reg_write_enable 0, reg_write_addr 0, reg_write_data 0.
- in_ready is 1 immediately after reset.
- Non-MEM request: latency 1. The write strobe is high in the cycle after acceptance, for exactly one cycle.
- MEM request: the strobe is high in the cycle after the edge on which mem_readvalid = 1 is sampled.
- Throughput is one request per cycle when memory answers in the acceptance cycle.
- reg_write_enable is 0 in any cycle with no completed result.
- Back-to-back requests in IDLE produce consecutive strobes.
- Reset asserted mid-WAIT_MEM drops the pending load: no write occurs, and a late mem_readvalid after reset is ignored.
- in_ready is combinational from state only and never depends on in_valid.

## Configuration

- `WB_SUBWORD_EN` defined: the full load_type decode, byte/halfword extension and LWL/LWR merge are implemented.
- `WB_SUBWORD_EN` undefined:
  - load_type, byte_off and rt_old are ignored.
  - Every MEM load writes mem_readdata unmodified.
  - The formatter is not instantiated.
  - All handshake and timing behaviour is unchanged.

## Structure

- Shared package: wb_select_t (ALU/MEM/IMM/LINK), load_type_t enum, state enum.
- Sub-module load_formatter: combinational; inputs load_type, byte_off, mem word and rt_old; output is the formatted word. It is instantiated only under `WB_SUBWORD_EN`.
- FSM, latch registers and output registers stay in reg_writeback_stage.

## Test plan

- ALU request: aluout = 0x1234_5678, dest = 5. Next cycle: enable = 1, addr = 5, data = 0x1234_5678; the cycle after: enable = 0.
- LB with mem_readdata = 0x80FF_7F01, byte_off = 3, readvalid in the same cycle. Next cycle: data = 0xFFFF_FF80. With LBU and the same inputs: data = 0x0000_0080.
- LWL with rt_old = 0xAABB_CCDD, mem = 0x1122_3344, off = 1 gives 0x3344_CCDD. LWR with the same values gives 0xAA11_2233.
- MEM request with readvalid delayed 3 cycles:
  - in_ready = 0 for those 3 cycles.
  - The strobe fires one cycle after readvalid.
  - A second in_valid held during the wait is accepted only after the return to IDLE.
- Reset pulsed while in WAIT_MEM, then readvalid = 1: no strobe occurs, outputs stay 0, and in_ready = 1.
- LINK request with dest = 0: data = link_pc is registered and the enable stays 0.
